sid_cfg_ctrl: RTL
=================

# sid_cfg_ctrl

Runtime configuration controller for the SID core. It holds the active `sid::cfg_t` words for SID 1 and SID 2, and lets the host reprogram them through an unlock/stage/commit sequence on the unused SID registers $1D–$1F. Staged values reach the outputs only at a pipeline-idle instant, so a configuration change never lands in the middle of a voice or filter sample. It sits beside `sid_control` and feeds the `sid1_cfg`/`sid2_cfg` nets consumed by chip-select decode, model selection and `sid_filter`.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `res`  in  1  synchronous active-high reset.
- `tick_ms`  in  1  single-cycle pulse, roughly 1 kHz.
- `voice_cycle`  in  `sid::cycle_t`  voice pipeline cycle; 0 means idle.
- `filter_cycle`  in  `sid::cycle_t`  filter pipeline cycle; 0 means idle.
- `cs`  in  2  decoded SID chip selects.
- `wr`  in  1  single-cycle bus write strobe.
- `addr`  in  5  register address.
- `wdata`  in  8  write data.
- `rdata`  out  8  staged byte at the pointer.
- `rdata_oe`  out  1  high when `rdata` is to be returned on a bus read.
- `unlocked`  out  1  high in the UNLOCKED state.
- `sid1_cfg`  out  `sid::cfg_t`  active SID 1 configuration.
- `sid2_cfg`  out  `sid::cfg_t`  active SID 2 configuration.

## Operation
- **Accepted write:** `wr & cs[0]` with `addr` in $1D–$1F. Every other write is ignored.
- **State machine:** LOCKED, KEY1, KEY2, UNLOCKED, PENDING.
- **Unlock key:** three consecutive $1F writes of 0x52, 0x44, 0x50.
  - LOCKED to KEY1, KEY1 to KEY2, KEY2 to UNLOCKED.
  - A wrong byte to $1F in KEY1 or KEY2 returns to LOCKED.
  - Writes to $1D/$1E before UNLOCKED are ignored and do not advance the key.
- **Entering UNLOCKED:**
  - The shadow image is loaded from the active configuration.
  - The pointer is cleared to 0.
- **Shadow image:** 10 bytes.
  - Byte 0: bit0 = sid1 model, bit1 = sid2 model.
  - Byte 1: bits[2:0] = sid2 addr (bit0 D420, bit1 D500, bit2 DE00; 0 = D400).
  - Bytes 2–3: sid1 9-bit field, little-endian.
  - Bytes 4–5: sid1 11-bit signed field.
  - Bytes 6–7: sid2 9-bit field.
  - Bytes 8–9: sid2 11-bit signed field.
  - Unused high bits are written as don't-care and read back as 0.
- **Writes in UNLOCKED:**
  - $1D: pointer <= `wdata[3:0]`, saturated to 10.
  - $1E: if pointer < 10, write the shadow byte at the pointer. The pointer then increments, saturating at 10.
  - $1F = 0x43 (commit): go to PENDING.
  - $1F = 0x41 (abort): go to LOCKED and discard the shadow.
  - $1F with any other byte: ignored.
- **PENDING:**
  - All writes are ignored.
  - On the first `clk` with `voice_cycle == 0 && filter_cycle == 0`, the outputs load from the shadow and the state goes to LOCKED.
- **Readback:**
  - `rdata_oe = unlocked & (addr == 5'h1E)`.
  - `rdata` = shadow byte at the pointer, or 0x00 when pointer = 10.
  - Reads never move the pointer.
- **Reset:**
  - state = LOCKED, `unlocked` = 0, `rdata_oe` = 0, pointer = 0, timeout counter = 0.
  - `sid1_cfg` = `sid2_cfg` = {MOS6581, D400, 9'd250, 11'sd0}.
  - Reset overrides a simultaneous write or commit, including a reset during PENDING (defaults are restored and the shadow is dropped).

## Timing
- All state, the pointer and the shadow update on the `clk` edge after an accepted `wr`. `unlocked` and `rdata` reflect the write from the next cycle.
- **Commit latency:** from the $1F write, 1 cycle to PENDING, then 0 or more cycles waiting for idle. The outputs change exactly one edge after the idle cycle is sampled.
- The outputs never change while `filter_cycle != 0` or `voice_cycle != 0`.
- **Timeout:**
  - An 8-bit counter increments on `tick_ms` in KEY1, KEY2 and UNLOCKED.
  - It clears on any accepted write and on entry to LOCKED.
  - At 255 the state goes to LOCKED and the shadow is discarded.
  - PENDING is exempt from the timeout.
- If `tick_ms` and an accepted write occur in the same cycle, the write wins and the counter clears.

## Configuration
- `SID_CFG_TIMEOUT_EN`:
  - Defined: the tick_ms timeout above is active.
  - Undefined: no counter is built, `tick_ms` is unused, and KEY and UNLOCKED states persist until a wrong key byte, abort, commit or `res`.

## Test plan
- Reset, then check outputs: `sid1_cfg` = `sid2_cfg` = {6581, D400, 250, 0}, `unlocked` = 0, `rdata_oe` = 0.
- Write $1F: 52, 44, 50; $1D = 1; $1E = 0x04; $1F = 0x43, with `filter_cycle` held at 7 for 20 cycles, then released to 0 → `sid2_cfg.addr` = DE00 exactly one edge after both cycles reach 0, not before.
- Send key 52, 45 → LOCKED; then writes to $1E are ignored and `rdata_oe` stays 0.
- Unlock, $1D = 2, write $1E = 0x2C, 0x01, then read $1E with pointer = 4 → `rdata` = 0x00. After commit, sid1 9-bit field = 300.
- With `SID_CFG_TIMEOUT_EN`: unlock, then 255 `tick_ms` pulses with no writes → `unlocked` = 0, config unchanged. A write at pulse 254 restarts the count.
- Assert `res` during PENDING → defaults restored, a later idle cycle applies nothing, state = LOCKED.

Source files
------------

// File: rtl/sid_cfg_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_cfg_ctrl_if : host register bus seen by sid_cfg_ctrl.                  |
// | Revision        : 1.0  initial release                                     |
// +----------------------------------------------------------------------------+

interface sid_cfg_ctrl_if;
  logic [1:0] cs;
  logic       wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_oe;

  modport master (output cs, output wr, output addr, output wdata,
                  input rdata, input rdata_oe);
  modport slave  (input cs, input wr, input addr, input wdata,
                  output rdata, output rdata_oe);
endinterface
`default_nettype wire

// File: rtl/sid_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_cfg_ctrl : runtime SID configuration controller (unlock/stage/commit   |
// |   on $1D-$1F). Optional macro SID_CFG_TIMEOUT_EN enables the tick timeout. |
// | Revision     : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+

package sid;
  typedef logic [4:0] cycle_t;

  localparam logic MOS6581 = 1'b0;
  localparam logic MOS8580 = 1'b1;

  // addr: bit0 D420, bit1 D500, bit2 DE00, all zero selects D400
  typedef struct packed {
    logic              model;
    logic [2:0]        addr;
    logic [8:0]        fc_base;
    logic signed [10:0] fc_tune;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{model: MOS6581, addr: 3'b000,
                                   fc_base: 9'd250, fc_tune: 11'sd0};
endpackage

module sid_cfg_ctrl (
  input  logic         clk,
  input  logic         res,
  input  logic         tick_ms,
  input  sid::cycle_t  voice_cycle,
  input  sid::cycle_t  filter_cycle,
  sid_cfg_ctrl_if.slave bus,
  output logic         unlocked,
  output sid::cfg_t    sid1_cfg,
  output sid::cfg_t    sid2_cfg
);

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_KEY1     = 3'd1,
    ST_KEY2     = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_PENDING  = 3'd4
  } state_t;

  localparam logic [7:0] KEY_0      = 8'h52;
  localparam logic [7:0] KEY_1      = 8'h44;
  localparam logic [7:0] KEY_2      = 8'h50;
  localparam logic [7:0] CMD_COMMIT = 8'h43;
  localparam logic [7:0] CMD_ABORT  = 8'h41;
  localparam logic [3:0] PTR_END    = 4'd10;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_ptr, w_ptr_nxt;
  sid::cfg_t  r_sh1, r_sh2, w_sh1_nxt, w_sh2_nxt;
  sid::cfg_t  r_cfg1, r_cfg2, w_cfg1_nxt, w_cfg2_nxt;

  logic w_acc, w_ptr_wr, w_data_wr, w_key_wr, w_idle;
  logic w_unused;

  assign w_acc     = bus.wr & bus.cs[0] &
                     ((bus.addr == 5'h1D) | (bus.addr == 5'h1E) | (bus.addr == 5'h1F));
  assign w_ptr_wr  = w_acc & (bus.addr == 5'h1D);
  assign w_data_wr = w_acc & (bus.addr == 5'h1E);
  assign w_key_wr  = w_acc & (bus.addr == 5'h1F);
  assign w_idle    = (voice_cycle == '0) && (filter_cycle == '0);

`ifdef SID_CFG_TIMEOUT_EN
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_timed;
  assign w_timed  = (r_state == ST_KEY1) || (r_state == ST_KEY2) || (r_state == ST_UNLOCKED);
  assign w_unused = bus.cs[1];
`else
  assign w_unused = bus.cs[1] ^ tick_ms;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sh1_nxt   = r_sh1;
    w_sh2_nxt   = r_sh2;
    w_cfg1_nxt  = r_cfg1;
    w_cfg2_nxt  = r_cfg2;
`ifdef SID_CFG_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      ST_LOCKED: begin
        if (w_key_wr && bus.wdata == KEY_0) w_state_nxt = ST_KEY1;
      end
      ST_KEY1: begin
        if (w_key_wr) w_state_nxt = (bus.wdata == KEY_1) ? ST_KEY2 : ST_LOCKED;
      end
      ST_KEY2: begin
        if (w_key_wr) begin
          if (bus.wdata == KEY_2) begin
            w_state_nxt = ST_UNLOCKED;
            w_sh1_nxt   = r_cfg1;
            w_sh2_nxt   = r_cfg2;
            w_ptr_nxt   = '0;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if (w_ptr_wr) begin
          w_ptr_nxt = (bus.wdata[3:0] > PTR_END) ? PTR_END : bus.wdata[3:0];
        end else if (w_data_wr && r_ptr < PTR_END) begin
          // Upper bits outside each field are dropped here so readback shows 0
          case (r_ptr)
            4'd0: begin
              w_sh1_nxt.model = bus.wdata[0];
              w_sh2_nxt.model = bus.wdata[1];
            end
            4'd1:    w_sh2_nxt.addr          = bus.wdata[2:0];
            4'd2:    w_sh1_nxt.fc_base[7:0]  = bus.wdata;
            4'd3:    w_sh1_nxt.fc_base[8]    = bus.wdata[0];
            4'd4:    w_sh1_nxt.fc_tune[7:0]  = bus.wdata;
            4'd5:    w_sh1_nxt.fc_tune[10:8] = bus.wdata[2:0];
            4'd6:    w_sh2_nxt.fc_base[7:0]  = bus.wdata;
            4'd7:    w_sh2_nxt.fc_base[8]    = bus.wdata[0];
            4'd8:    w_sh2_nxt.fc_tune[7:0]  = bus.wdata;
            4'd9:    w_sh2_nxt.fc_tune[10:8] = bus.wdata[2:0];
            default: ;
          endcase
          w_ptr_nxt = r_ptr + 4'd1;
        end else if (w_key_wr) begin
          if (bus.wdata == CMD_COMMIT)     w_state_nxt = ST_PENDING;
          else if (bus.wdata == CMD_ABORT) w_state_nxt = ST_LOCKED;
        end
      end
      ST_PENDING: begin
        if (w_idle) begin
          w_cfg1_nxt  = r_sh1;
          w_cfg2_nxt  = r_sh2;
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
`ifdef SID_CFG_TIMEOUT_EN
    if (!w_timed || w_acc) begin
      w_cnt_nxt = '0;
    end else if (tick_ms) begin
      // The 255th tick without a write locks the controller
      if (r_cnt == 8'd254) begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_LOCKED;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_LOCKED;
      r_ptr   <= '0;
      r_sh1   <= sid::CFG_DEFAULT;
      r_sh2   <= sid::CFG_DEFAULT;
      r_cfg1  <= sid::CFG_DEFAULT;
      r_cfg2  <= sid::CFG_DEFAULT;
`ifdef SID_CFG_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sh1   <= w_sh1_nxt;
      r_sh2   <= w_sh2_nxt;
      r_cfg1  <= w_cfg1_nxt;
      r_cfg2  <= w_cfg2_nxt;
`ifdef SID_CFG_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  always_comb begin
    bus.rdata = 8'h00;
    case (r_ptr)
      4'd0:    bus.rdata = {6'b0, r_sh2.model, r_sh1.model};
      4'd1:    bus.rdata = {5'b0, r_sh2.addr};
      4'd2:    bus.rdata = r_sh1.fc_base[7:0];
      4'd3:    bus.rdata = {7'b0, r_sh1.fc_base[8]};
      4'd4:    bus.rdata = r_sh1.fc_tune[7:0];
      4'd5:    bus.rdata = {5'b0, r_sh1.fc_tune[10:8]};
      4'd6:    bus.rdata = r_sh2.fc_base[7:0];
      4'd7:    bus.rdata = {7'b0, r_sh2.fc_base[8]};
      4'd8:    bus.rdata = r_sh2.fc_tune[7:0];
      4'd9:    bus.rdata = {5'b0, r_sh2.fc_tune[10:8]};
      default: bus.rdata = 8'h00;
    endcase
  end

  assign unlocked     = (r_state == ST_UNLOCKED);
  assign bus.rdata_oe = unlocked & (bus.addr == 5'h1E);
  assign sid1_cfg     = r_cfg1;
  assign sid2_cfg     = r_cfg2;

endmodule
`default_nettype wire
